// File: rtl/aucohl_tmr32_irq.sv
`default_nettype none
// ============================================================================
// Module   : aucohl_tmr32_irq
// Brief    : Edge-detects timer/PWM level flags into sticky status bits and
//            produces one registered, masked interrupt request.
//            Optional timeout coalescing: AUCOHL_TMR32_IRQ_COALESCE_EN
// Revision : 1.0
// ============================================================================
module aucohl_tmr32_irq #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          matchx_flag,
    input  logic          matchy_flag,
    input  logic          timeout_flag,
    input  logic          pwm_fault,
    input  logic [3:0]    im,
    input  logic [3:0]    icr,
    input  logic [CW-1:0] coal_thr,
    output logic [3:0]    ris,
    output logic [3:0]    mis,
    output logic [3:0]    ovr,
    output logic [CW-1:0] coal_cnt,
    output logic          irq
);

    logic [3:0] w_lvl;
    logic [3:0] r_prev;
    logic [3:0] w_raw_evt;
    logic [3:0] w_evt;
    logic [3:0] r_ris;
    logic [3:0] r_ovr;
    logic [3:0] w_ris_nxt;
    logic [3:0] w_ovr_nxt;
    logic       w_to_evt;
    logic       r_irq;

    assign w_lvl     = {pwm_fault, timeout_flag, matchy_flag, matchx_flag};
    // prev resets high so a flag already asserted at reset release is ignored
    assign w_raw_evt = w_lvl & ~r_prev;

`ifdef AUCOHL_TMR32_IRQ_COALESCE_EN
    localparam logic [CW-1:0] C_CNT_MAX = '1;
    localparam logic [CW-1:0] C_CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    logic [CW-1:0] r_coal_cnt;
    logic [CW-1:0] w_cnt_inc;
    logic          w_coal_hit;

    // saturating increment; a threshold of 0 or 1 is met by every event
    assign w_cnt_inc  = (r_coal_cnt == C_CNT_MAX) ? C_CNT_MAX : r_coal_cnt + C_CNT_ONE;
    assign w_coal_hit = (w_cnt_inc >= coal_thr);
    assign w_to_evt   = w_raw_evt[2] & w_coal_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_coal_cnt <= '0;
        end else if (w_raw_evt[2]) begin
            r_coal_cnt <= w_coal_hit ? '0 : w_cnt_inc;
        end
    end

    assign coal_cnt = r_coal_cnt;
`else
    logic w_unused_thr;

    assign w_unused_thr = ^coal_thr;
    assign w_to_evt     = w_raw_evt[2];
    assign coal_cnt     = '0;
`endif

    assign w_evt = {w_raw_evt[3], w_to_evt, w_raw_evt[1:0]};

    // set beats clear on ris; clear always wins on ovr
    assign w_ris_nxt = w_evt | (r_ris & ~icr);
    assign w_ovr_nxt = ~icr & (r_ovr | (w_evt & r_ris));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= 4'hF;
            r_ris  <= 4'h0;
            r_ovr  <= 4'h0;
            r_irq  <= 1'b0;
        end else begin
            r_prev <= w_lvl;
            r_ris  <= w_ris_nxt;
            r_ovr  <= w_ovr_nxt;
            r_irq  <= |(r_ris & im);
        end
    end

    assign ris = r_ris;
    assign ovr = r_ovr;
    assign mis = r_ris & im;
    assign irq = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_aucohl_tmr32_irq.sv
`default_nettype none
// ============================================================================
// Module   : tb_aucohl_tmr32_irq
// Brief    : Directed self-checking bench for aucohl_tmr32_irq; expectations
//            follow AUCOHL_TMR32_IRQ_COALESCE_EN when it is defined.
// Revision : 1.0
// ============================================================================
module tb_aucohl_tmr32_irq;

    localparam int CW = 8;

    logic          clk;
    logic          rst_n;
    logic          matchx_flag;
    logic          matchy_flag;
    logic          timeout_flag;
    logic          pwm_fault;
    logic [3:0]    im;
    logic [3:0]    icr;
    logic [CW-1:0] coal_thr;
    logic [3:0]    ris;
    logic [3:0]    mis;
    logic [3:0]    ovr;
    logic [CW-1:0] coal_cnt;
    logic          irq;

    int n_vec;
    int n_err;

    aucohl_tmr32_irq #(.CW(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .matchx_flag  (matchx_flag),
        .matchy_flag  (matchy_flag),
        .timeout_flag (timeout_flag),
        .pwm_fault    (pwm_fault),
        .im           (im),
        .icr          (icr),
        .coal_thr     (coal_thr),
        .ris          (ris),
        .mis          (mis),
        .ovr          (ovr),
        .coal_cnt     (coal_cnt),
        .irq          (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [CW-1:0] exp_cnt [5];
        logic          exp_ris2[5];
        logic          exp_ovr2[5];

        n_vec = 0;
        n_err = 0;
`ifdef AUCOHL_TMR32_IRQ_COALESCE_EN
        exp_cnt  = '{8'd1, 8'd2, 8'd0, 8'd1, 8'd2};
        exp_ris2 = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        exp_ovr2 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`else
        exp_cnt  = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        exp_ris2 = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        exp_ovr2 = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
`endif

        // reset with matchx already high
        rst_n = 1'b0; matchx_flag = 1'b1; matchy_flag = 1'b0; timeout_flag = 1'b0;
        pwm_fault = 1'b0; im = 4'h0; icr = 4'h0; coal_thr = 8'd3;
        tick(); tick();
        check("rst_ris", ris, 4'h0);
        check("rst_ovr", ovr, 4'h0);
        check("rst_cnt", coal_cnt, 0);
        check("rst_irq", irq, 0);
        check("rst_mis", mis, 4'h0);
        rst_n = 1'b1; im = 4'hF;
        repeat (10) tick();
        check("held_ris", ris, 4'h0);
        check("held_irq", irq, 0);
        matchx_flag = 1'b0; im = 4'h0;
        tick();

        // matchy single event, then clear
        im = 4'b0010; matchy_flag = 1'b1;
        tick();
        check("my_ris", ris, 4'b0010);
        check("my_mis", mis, 4'b0010);
        check("my_irq0", irq, 0);
        tick();
        check("my_irq1", irq, 1);
        repeat (18) tick();
        check("my_hold_ris", ris, 4'b0010);
        check("my_hold_ovr", ovr, 4'h0);
        matchy_flag = 1'b0; icr = 4'b0010;
        tick();
        icr = 4'h0;
        check("my_clr_ris", ris, 4'h0);
        check("my_clr_mis", mis, 4'h0);
        check("my_clr_irq_lag", irq, 1);
        tick();
        check("my_clr_irq", irq, 0);

        // two fault edges, masked then unmasked
        im = 4'h0;
        pwm_fault = 1'b1; tick(); pwm_fault = 1'b0; tick();
        pwm_fault = 1'b1; tick(); pwm_fault = 1'b0; tick();
        check("flt_ris", ris, 4'b1000);
        check("flt_ovr", ovr, 4'b1000);
        check("flt_irq_masked", irq, 0);
        im = 4'b1000;
        #1;
        check("flt_mis", mis, 4'b1000);
        tick();
        check("flt_irq", irq, 1);
        icr = 4'b1000; tick(); icr = 4'h0;
        check("flt_clr_ris", ris, 4'h0);
        check("flt_clr_ovr", ovr, 4'h0);

        // matchx event coinciding with its clear
        im = 4'h0;
        matchx_flag = 1'b1; tick(); matchx_flag = 1'b0; tick();
        check("mx_pre_ris", ris, 4'b0001);
        matchx_flag = 1'b1; icr = 4'b0001;
        tick();
        icr = 4'h0; matchx_flag = 1'b0;
        check("mx_sc_ris", ris, 4'b0001);
        check("mx_sc_ovr", ovr, 4'b0000);
        icr = 4'hF; tick(); icr = 4'h0;

        // timeout coalescing, threshold 3
        coal_thr = 8'd3;
        for (int i = 0; i < 5; i++) begin
            timeout_flag = 1'b1; tick();
            check($sformatf("to_cnt%0d", i), coal_cnt, exp_cnt[i]);
            check($sformatf("to_ris%0d", i), ris[2], exp_ris2[i]);
            check($sformatf("to_ovr%0d", i), ovr[2], exp_ovr2[i]);
            timeout_flag = 1'b0; tick();
        end

        // threshold lowered below current count fires on next event
        icr = 4'hF; tick(); icr = 4'h0;
        coal_thr = 8'd1;
        timeout_flag = 1'b1; tick();
        check("lower_ris", ris[2], 1);
        check("lower_cnt", coal_cnt, 0);
        timeout_flag = 1'b0; tick();

`ifdef AUCOHL_TMR32_IRQ_COALESCE_EN
        // threshold at saturation value
        icr = 4'hF; tick(); icr = 4'h0;
        coal_thr = 8'hFF;
        repeat (254) begin
            timeout_flag = 1'b1; tick(); timeout_flag = 1'b0; tick();
        end
        check("sat_cnt_pre", coal_cnt, 8'hFE);
        check("sat_ris_pre", ris[2], 0);
        timeout_flag = 1'b1; tick(); timeout_flag = 1'b0; tick();
        check("sat_cnt", coal_cnt, 0);
        check("sat_ris", ris[2], 1);
        // count up then check mid-operation reset clears the counter
        coal_thr = 8'd10;
        timeout_flag = 1'b1; tick(); timeout_flag = 1'b0; tick();
        check("pre_rst_cnt", coal_cnt, 1);
`endif

        // mid-operation reset with matchx held high
        im = 4'h1;
        matchx_flag = 1'b1; tick(); tick();
        check("mid_pre_irq", irq, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ris", ris, 4'h0);
        check("mid_rst_irq", irq, 0);
        check("mid_rst_cnt", coal_cnt, 0);
        tick();
        rst_n = 1'b1;
        tick(); tick();
        check("mid_rel_ris", ris, 4'h0);
        check("mid_rel_irq", irq, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
